// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Purpose  : Round-robin sharing of one I2C byte-master between two clients;
//            optional watchdog abort built when I2C_ARB_WATCHDOG_EN is defined.
// Revision : 1.0
// ============================================================================
module i2c_bus_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       c0_start,
    input  logic       c1_start,
    input  logic       c0_send,
    input  logic       c1_send,
    input  logic       c0_receive,
    input  logic       c1_receive,
    input  logic [7:0] c0_datasend,
    input  logic [7:0] c1_datasend,
    output logic       c0_isReady,
    output logic       c1_isReady,
    output logic       c0_sended,
    output logic       c1_sended,
    output logic       c0_received,
    output logic       c1_received,
    output logic [7:0] c0_datareceive,
    output logic [7:0] c1_datareceive,
    output logic       m_start,
    output logic       m_send,
    output logic       m_receive,
    output logic [7:0] m_datasend,
    input  logic       m_isReady,
    input  logic       m_sended,
    input  logic       m_received,
    input  logic [7:0] m_datareceive,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_ABORT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_gnt0;
    logic   r_gnt1;
    logic   r_owner;
    logic   r_last;
    logic   w_gnt0_nxt;
    logic   w_gnt1_nxt;
    logic   w_owner_nxt;
    logic   w_last_nxt;
    logic   w_pick;
    logic   w_owner_req;
    logic   w_grant_start;
    logic   w_err_set;
    logic   w_expire;

    // On a tie the client that was not served last wins; otherwise the lone requester.
    assign w_pick      = (req0 && req1) ? ~r_last : req1;
    assign w_owner_req = r_owner ? req1 : req0;

`ifdef I2C_ARB_WATCHDOG_EN
    logic [23:0] r_cnt;
    logic        r_timeout_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 24'd0;
        end else if (w_grant_start) begin
            r_cnt <= 24'd0;
        end else if (r_state == S_GRANT) begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

    assign w_expire = (r_state == S_GRANT) && (r_cnt == TIMEOUT - 24'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_err_set) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^{TIMEOUT, w_err_set, w_grant_start};
    assign w_expire         = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt0_nxt    = r_gnt0;
        w_gnt1_nxt    = r_gnt1;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_grant_start = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt   = S_GRANT;
                    w_owner_nxt   = w_pick;
                    w_gnt0_nxt    = ~w_pick;
                    w_gnt1_nxt    = w_pick;
                    w_grant_start = 1'b1;
                end
            end
            S_GRANT: begin
                // A dropped request takes priority over a simultaneous watchdog expiry.
                if (!w_owner_req) begin
                    w_state_nxt = S_RELEASE;
                    w_gnt0_nxt  = 1'b0;
                    w_gnt1_nxt  = 1'b0;
                end else if (w_expire) begin
                    w_state_nxt = S_ABORT;
                    w_gnt0_nxt  = 1'b0;
                    w_gnt1_nxt  = 1'b0;
                    w_err_set   = 1'b1;
                end
            end
            S_ABORT: begin
                w_gnt0_nxt = 1'b0;
                w_gnt1_nxt = 1'b0;
                if (m_isReady) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Never hand over a master that is still mid-transaction.
                w_gnt0_nxt = 1'b0;
                w_gnt1_nxt = 1'b0;
                w_last_nxt = r_owner;
                if (m_isReady) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt0_nxt  = 1'b0;
                w_gnt1_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign gnt0 = r_gnt0;
    assign gnt1 = r_gnt1;
    assign busy = r_gnt0 | r_gnt1;

    // Routing follows the registered grant only, so reset forces everything idle at once.
    always_comb begin
        m_start    = 1'b1;
        m_send     = 1'b0;
        m_receive  = 1'b0;
        m_datasend = 8'h00;
        if (r_gnt0) begin
            m_start    = c0_start;
            m_send     = c0_send;
            m_receive  = c0_receive;
            m_datasend = c0_datasend;
        end else if (r_gnt1) begin
            m_start    = c1_start;
            m_send     = c1_send;
            m_receive  = c1_receive;
            m_datasend = c1_datasend;
        end
    end

    assign c0_isReady     = r_gnt0 & m_isReady;
    assign c0_sended      = r_gnt0 & m_sended;
    assign c0_received    = r_gnt0 & m_received;
    assign c0_datareceive = r_gnt0 ? m_datareceive : 8'h00;
    assign c1_isReady     = r_gnt1 & m_isReady;
    assign c1_sended      = r_gnt1 & m_sended;
    assign c1_received    = r_gnt1 & m_received;
    assign c1_datareceive = r_gnt1 ? m_datareceive : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_arbiter
// Purpose  : Directed plus randomized self-checking bench for i2c_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_i2c_bus_arbiter;

    localparam int TMO = 100;
`ifdef I2C_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       c0_start = 1'b1, c1_start = 1'b1;
    logic       c0_send = 1'b0, c1_send = 1'b0;
    logic       c0_receive = 1'b0, c1_receive = 1'b0;
    logic [7:0] c0_datasend = 8'h00, c1_datasend = 8'h00;
    logic       m_isReady = 1'b1, m_sended = 1'b0, m_received = 1'b0;
    logic [7:0] m_datareceive = 8'h00;

    logic       gnt0, gnt1, busy, timeout_err;
    logic       c0_isReady, c1_isReady, c0_sended, c1_sended, c0_received, c1_received;
    logic [7:0] c0_datareceive, c1_datareceive;
    logic       m_start, m_send, m_receive;
    logic [7:0] m_datasend;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.TIMEOUT(24'd100)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .c0_start(c0_start), .c1_start(c1_start),
        .c0_send(c0_send), .c1_send(c1_send),
        .c0_receive(c0_receive), .c1_receive(c1_receive),
        .c0_datasend(c0_datasend), .c1_datasend(c1_datasend),
        .c0_isReady(c0_isReady), .c1_isReady(c1_isReady),
        .c0_sended(c0_sended), .c1_sended(c1_sended),
        .c0_received(c0_received), .c1_received(c1_received),
        .c0_datareceive(c0_datareceive), .c1_datareceive(c1_datareceive),
        .m_start(m_start), .m_send(m_send), .m_receive(m_receive),
        .m_datasend(m_datasend),
        .m_isReady(m_isReady), .m_sended(m_sended), .m_received(m_received),
        .m_datareceive(m_datareceive),
        .busy(busy), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how many master-idle steps remain
    // before a new grant may be issued, and how long the current grant has run.
    int mo_own  = -1;
    int mo_wait = 0;
    int mo_age  = 0;
    bit mo_last = 1'b1;
    bit mo_err  = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mo_own  = -1;
            mo_wait = 0;
            mo_age  = 0;
            mo_last = 1'b1;
            mo_err  = 1'b0;
        end else if (mo_own >= 0) begin
            if (!(mo_own == 0 ? req0 : req1)) begin
                mo_last = (mo_own == 1);
                mo_own  = -1;
                mo_wait = 1;
            end else if (WD && mo_age == TMO - 1) begin
                mo_last = (mo_own == 1);
                mo_own  = -1;
                mo_wait = 2;
                mo_err  = 1'b1;
            end else begin
                mo_age++;
            end
        end else if (mo_wait > 0) begin
            if (m_isReady) mo_wait--;
        end else if (req0 || req1) begin
            mo_own = (req0 && req1) ? (mo_last ? 0 : 1) : (req0 ? 0 : 1);
            mo_age = 0;
        end
    end

    logic        e0, e1;
    logic [10:0] exp_m;
    always @(negedge clk) begin
        if (chk_en) begin
            e0 = (mo_own == 0);
            e1 = (mo_own == 1);
            exp_m = e0 ? {c0_start, c0_send, c0_receive, c0_datasend} :
                    e1 ? {c1_start, c1_send, c1_receive, c1_datasend} : {1'b1, 10'h000};
            check("grants", 32'({gnt0, gnt1, busy, timeout_err}), 32'({e0, e1, e0 | e1, mo_err}));
            check("master", 32'({m_start, m_send, m_receive, m_datasend}), 32'(exp_m));
            check("client0", 32'({c0_isReady, c0_sended, c0_received, c0_datareceive}),
                  e0 ? 32'({m_isReady, m_sended, m_received, m_datareceive}) : 32'd0);
            check("client1", 32'({c1_isReady, c1_sended, c1_received, c1_datareceive}),
                  e1 ? 32'({m_isReady, m_sended, m_received, m_datareceive}) : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n;
    logic [7:0] b;

    initial begin
        step();
        step();
        chk_en = 1'b1;
        check("rst_gnt", 32'({gnt0, gnt1, busy, timeout_err}), 32'd0);
        check("rst_master", 32'({m_start, m_send, m_receive, m_datasend}), 32'h400);
        check("rst_c0", 32'({c0_isReady, c0_datareceive}), 32'd0);
        reset = 1'b1;
        step();

        // Single client, three-byte write
        req0 = 1'b1;
        step();
        check("single_gnt0", 32'(gnt0), 32'd1);
        check("single_c0rdy", 32'(c0_isReady), 32'd1);
        c0_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b = 8'hA0 + 8'(i * 17);
            c0_datasend = b;
            c0_send = 1'b1;
            m_isReady = 1'b0;
            step();
            check("single_data", 32'(m_datasend), 32'(b));
            check("single_c1rdy", 32'(c1_isReady), 32'd0);
            m_sended = 1'b1;
            c0_send = 1'b0;
            step();
            check("single_sended", 32'({c0_sended, c1_sended}), 32'b10);
            m_sended = 1'b0;
            m_isReady = 1'b1;
            step();
        end
        c0_start = 1'b1;
        req0 = 1'b0;
        step();
        check("single_drop", 32'(gnt0), 32'd0);
        step();
        step();

        // Tie after reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        check("tie_first", 32'({gnt0, gnt1}), 32'b10);
        for (int i = 0; i < 9; i++) step();
        req0 = 1'b0;
        step();
        check("tie_rel", 32'({gnt0, gnt1}), 32'b00);
        step();
        check("tie_idle", 32'(gnt1), 32'd0);
        step();
        check("tie_second", 32'({gnt0, gnt1}), 32'b01);
        for (int i = 0; i < 9; i++) step();
        req1 = 1'b0;
        step();
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        step();
        check("tie_again", 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();

        // Early drop while master busy
        req1 = 1'b1;
        step();
        check("early_g1", 32'(gnt1), 32'd1);
        m_isReady = 1'b0;
        req0 = 1'b1;
        step();
        req1 = 1'b0;
        step();
        check("early_rel", 32'(gnt1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("early_hold", 32'(gnt0), 32'd0);
        end
        m_isReady = 1'b1;
        step();
        check("early_idle", 32'(gnt0), 32'd0);
        step();
        check("early_gnt", 32'({gnt0, c0_isReady}), 32'b11);
        req0 = 1'b0;
        step();
        step();
        step();

        // Asynchronous reset in the middle of a grant
        req0 = 1'b1;
        c0_start = 1'b0;
        step();
        check("rstmid_pre", 32'({gnt0, m_start}), 32'b10);
        #2 reset = 1'b0;
        #1;
        check("rstmid", 32'({gnt0, m_start, busy}), 32'b010);
        step();
        reset = 1'b1;
        req0 = 1'b0;
        c0_start = 1'b1;
        step();

        // Watchdog: request held indefinitely
        req0 = 1'b1;
        c0_start = 1'b0;
        step();
        n = 0;
        while (gnt0 && n < 150) begin
            n++;
            step();
        end
`ifdef I2C_ARB_WATCHDOG_EN
        check("wd_cycles", 32'(n), 32'd100);
        check("wd_abort", 32'({gnt0, timeout_err, m_start}), 32'b011);
`else
        check("wd_persist", 32'(n), 32'd150);
        check("wd_nogrant_err", 32'({gnt0, timeout_err}), 32'b10);
`endif
        req0 = 1'b0;
        c0_start = 1'b1;
        step();
        step();
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 9) == 0) req0 = ~req0;
            if ($urandom_range(0, 9) == 0) req1 = ~req1;
            c0_start      = 1'($urandom_range(0, 1));
            c1_start      = 1'($urandom_range(0, 1));
            c0_send       = 1'($urandom_range(0, 1));
            c1_send       = 1'($urandom_range(0, 1));
            c0_receive    = 1'($urandom_range(0, 1));
            c1_receive    = 1'($urandom_range(0, 1));
            c0_datasend   = 8'($urandom_range(0, 255));
            c1_datasend   = 8'($urandom_range(0, 255));
            m_isReady     = ($urandom_range(0, 3) != 0);
            m_sended      = 1'($urandom_range(0, 1));
            m_received    = 1'($urandom_range(0, 1));
            m_datareceive = 8'($urandom_range(0, 255));
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

- Shares one I2C byte-master between two sensor controllers, e.g. the BMP180 reader and a second bus client.
- Each client raises a level request and then uses its normal master handshake: `start`, `isReady`, `send`/`sended`, `receive`/`received`.
- The arbiter grants the bus round-robin for whole transactions and muxes the handshake to the granted client only.
- It isolates the idle client and, optionally, aborts a transaction that hangs.

## Interface
- `TIMEOUT`, default 24'd5_000_000: maximum grant length in clk cycles (watchdog build only).
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `req0` / `req1` input 1 each: client bus request; level, held for the whole transaction.
- `gnt0` / `gnt1` output 1 each: client owns the bus.
- `c0_start`, `c1_start` input 1: client start, active-low.
- `c0_send`, `c1_send` input 1: client send.
- `c0_receive`, `c1_receive` input 1: client receive.
- `c0_datasend`, `c1_datasend` input 8: client byte to transmit.
- `c0_isReady`, `c1_isReady` output 1: master `isReady` as seen by that client.
- `c0_sended`, `c1_sended` output 1: master `sended` as seen by that client.
- `c0_received`, `c1_received` output 1: master `received` as seen by that client.
- `c0_datareceive`, `c1_datareceive` output 8: master received byte as seen by that client.
- `m_start` output 1: to master, active-low.
- `m_send`, `m_receive` output 1: to master.
- `m_datasend` output 8: to master.
- `m_isReady`, `m_sended`, `m_received` input 1: from master.
- `m_datareceive` input 8: from master.
- `busy` output 1: a grant is active.
- `timeout_err` output 1: sticky watchdog flag.

## Operation
- States: IDLE, GRANT, ABORT, RELEASE. All control outputs are registered.
- Routing out of the arbiter:
  - Master-side outputs take the granted client's signals.
  - With no grant, master-side outputs are forced inactive: `m_start`=1, `m_send`=0, `m_receive`=0, `m_datasend`=0.
- Routing back to the clients:
  - The granted client sees the live master signals.
  - The non-granted client sees `isReady`=0, `sended`=0, `received`=0, `datareceive`=0.
  - Because `isReady` stays 0, the non-granted client never starts.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the client other than `last`, the 1-bit pointer to the previously served client.
  - Go to GRANT.
- GRANT:
  - Forward the handshake.
  - Granted req falls -> RELEASE.
  - Watchdog expires -> ABORT.
- ABORT:
  - Hold master outputs inactive.
  - Deassert the grant and set `timeout_err`.
  - When `m_isReady`=1 -> RELEASE.
- RELEASE:
  - All grants low; update `last`.
  - Stay here until `m_isReady`=1, so a client that drops req mid-transaction never hands over a busy master.
  - Then go to IDLE.
- `busy` = `gnt0 | gnt1`.
- `timeout_err` clears only on reset.

## Timing
- Reset values: state IDLE; `gnt0`=`gnt1`=0; `busy`=0; `timeout_err`=0; `last`=1, so `req0` wins the first tie; `m_start`=1; `m_send`=`m_receive`=0; `m_datasend`=0; all client-side outputs 0.
- Reset asserted mid-transaction:
  - Everything returns to reset values immediately and asynchronously.
  - The master sees `m_start`=1, `send`=0, `receive`=0.
- Grant latency: req high in IDLE at edge N -> gnt high after edge N+1.
- Routing is combinational from the registered grant, so a client sees live `isReady` in the same cycle its gnt rises.
- Release latency:
  - req low at edge N -> gnt low after edge N+1.
  - With the master idle, the next grant is earliest after edge N+3: RELEASE, IDLE, grant.
- Requests arriving while a grant is active are held pending; they are level-sensitive with no queue depth.
- A request that drops before being granted is ignored; no grant is issued.
- Watchdog:
  - A 24-bit counter clears on entry to GRANT and increments every cycle in GRANT.
  - On count == TIMEOUT-1 the FSM goes to ABORT, so the grant lasts exactly TIMEOUT cycles.
- If req falls on the same cycle the watchdog expires, release wins: RELEASE, and `timeout_err` is not set.

## Configuration
- `I2C_ARB_WATCHDOG_EN` defined:
  - The watchdog counter, the ABORT state and `timeout_err` are built.
- Not defined:
  - There is no counter and GRANT never times out.
  - `timeout_err` is tied to 0.
  - The `TIMEOUT` parameter is unused.

## Test plan
- Single client: pulse `req0` high, run one 3-byte write, master `isReady` 1->0->1, drop `req0`. Required:
  - `gnt0` high 1 cycle after `req0`.
  - `m_datasend` equals `c0_datasend`.
  - `c1_isReady`=0 throughout.
  - `gnt0` low 1 cycle after `req0` drops.
- Tie: `req0` and `req1` high together after reset, each held 10 cycles then dropped. Required:
  - `gnt0` is granted first.
  - `gnt1` is granted 3 cycles after `req0` drops.
  - In the next tie, `gnt0` wins again because `last`=1.
- Early drop: `req1` drops while `m_isReady`=0. Required:
  - The FSM stays in RELEASE until `m_isReady`=1.
  - A pending `req0` is granted 2 cycles after that.
- Watchdog (macro defined), TIMEOUT=100, `req0` held forever. Required:
  - `gnt0` falls after exactly 100 grant cycles.
  - `timeout_err`=1 and `m_start`=1.
  - With the macro undefined, the grant persists.
- Reset mid-grant: assert `reset`=0 asynchronously between clock edges. Required:
  - `gnt0`=0, `m_start`=1, `busy`=0 immediately, before the next edge.
